// File: rtl/ysyx_23060236_stbuf_pkg.sv
// Shared types and constants for the store buffer: FSM encodings, AXI
// response/burst codes and the layout of one buffered store.
package ysyx_23060236_stbuf_pkg;

  typedef enum logic [1:0] {
    D_IDLE = 2'd0,
    D_SEND = 2'd1,
    D_RESP = 2'd2
  } drain_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_ADDR = 2'd2,
    R_DATA = 2'd3
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef struct packed {
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] data;
    logic [3:0]  strb;
  } st_entry_t;

  localparam int ENTRY_W = $bits(st_entry_t);

endpackage

// File: rtl/ysyx_23060236_stbuf_fifo.sv
// Circular entry storage for the store buffer; DEPTH must be a power of two
// so the pointers wrap by plain overflow.
module ysyx_23060236_stbuf_fifo
  import ysyx_23060236_stbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic [ENTRY_W-1:0] push_data,
  input  logic               pop,
  output logic               full,
  output logic               empty,
  output logic [ENTRY_W-1:0] head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  always_comb begin
    wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign head  = mem_q[rptr_q];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Payload storage carries no reset; outputs that expose it are gated upstream.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= push_data;
  end

endmodule

// File: rtl/ysyx_23060236_stbuf.sv
// Posted-write store buffer between the LSU and the xbar: stores are acked
// immediately and drained in order; loads wait until the buffer is empty.
module ysyx_23060236_stbuf
  import ysyx_23060236_stbuf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] s_awaddr,
  input  logic [2:0]  s_awsize,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic [2:0]  s_arsize,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [3:0]  m_awid,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        empty,
  output logic        bus_err
);

  drain_state_e d_state_q, d_state_d;
  rd_state_e    r_state_q, r_state_d;
  logic         aw_pend_q, aw_pend_d;
  logic         w_pend_q, w_pend_d;
  logic         bvalid_q, bvalid_d;
  logic         bus_err_q, bus_err_d;
  logic [31:0]  ar_addr_q, ar_addr_d;
  logic [2:0]   ar_size_q, ar_size_d;

  logic               push, pop;
  logic               fifo_full, fifo_empty;
  st_entry_t          push_entry, head_entry;
  logic [ENTRY_W-1:0] head_bits;

  assign push = s_awvalid & s_wvalid & ~fifo_full & ~bvalid_q & (r_state_q == R_IDLE);

  always_comb begin
    push_entry      = '0;
    push_entry.addr = s_awaddr;
    push_entry.size = s_awsize;
    push_entry.data = s_wdata;
    push_entry.strb = s_wstrb;
  end

  ysyx_23060236_stbuf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head_bits)
  );

  assign head_entry = st_entry_t'(head_bits);

  always_comb begin
    d_state_d = d_state_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    bus_err_d = bus_err_q;
    pop       = 1'b0;
    bvalid_d  = push | (bvalid_q & ~s_bready);
    case (d_state_q)
      // Also wake on a push into an empty buffer so AW goes out the cycle after acceptance.
      D_IDLE: begin
        if (!fifo_empty || push) begin
          d_state_d = D_SEND;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
        end
      end
      D_SEND: begin
        aw_pend_d = aw_pend_q & ~m_awready;
        w_pend_d  = w_pend_q & ~m_wready;
        if (!aw_pend_d && !w_pend_d) d_state_d = D_RESP;
      end
      D_RESP: begin
        if (m_bvalid) begin
          pop       = 1'b1;
          d_state_d = D_IDLE;
          if (m_bresp != RESP_OKAY) bus_err_d = 1'b1;
        end
      end
      default: d_state_d = D_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    ar_addr_d = ar_addr_q;
    ar_size_d = ar_size_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_arvalid) begin
          ar_addr_d = s_araddr;
          ar_size_d = s_arsize;
          r_state_d = R_WAIT;
        end
      end
      R_WAIT:  if (empty) r_state_d = R_ADDR;
      R_ADDR:  if (m_arready) r_state_d = R_DATA;
      R_DATA:  if (m_rvalid && s_rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      d_state_q <= D_IDLE;
      r_state_q <= R_IDLE;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bus_err_q <= 1'b0;
      ar_addr_q <= '0;
      ar_size_q <= '0;
    end else begin
      d_state_q <= d_state_d;
      r_state_q <= r_state_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      bvalid_q  <= bvalid_d;
      bus_err_q <= bus_err_d;
      ar_addr_q <= ar_addr_d;
      ar_size_q <= ar_size_d;
    end
  end

  assign s_awready = push;
  assign s_wready  = push;
  assign s_bvalid  = bvalid_q;
  assign s_bresp   = RESP_OKAY;
  assign empty     = fifo_empty & (d_state_q == D_IDLE);
  assign bus_err   = bus_err_q;

  assign m_awid    = '0;
  assign m_awlen   = '0;
  assign m_awburst = BURST_INCR;
  assign m_awvalid = aw_pend_q;
  assign m_awaddr  = (d_state_q == D_SEND) ? head_entry.addr : '0;
  assign m_awsize  = (d_state_q == D_SEND) ? head_entry.size : '0;
  assign m_wdata   = (d_state_q == D_SEND) ? head_entry.data : '0;
  assign m_wstrb   = (d_state_q == D_SEND) ? head_entry.strb : '0;
  assign m_wvalid  = w_pend_q;
  assign m_wlast   = w_pend_q;
  assign m_bready  = (d_state_q == D_RESP);

  assign m_arid    = '0;
  assign m_arlen   = '0;
  assign m_arburst = BURST_INCR;
  assign m_arvalid = (r_state_q == R_ADDR);
  assign m_araddr  = ar_addr_q;
  assign m_arsize  = ar_size_q;
  assign s_arready = (r_state_q == R_ADDR) & m_arready;

  // Read data path is a pure pass-through while the load owns the bus.
  assign s_rvalid  = (r_state_q == R_DATA) & m_rvalid;
  assign s_rdata   = (r_state_q == R_DATA) ? m_rdata : '0;
  assign s_rresp   = (r_state_q == R_DATA) ? m_rresp : '0;
  assign m_rready  = (r_state_q == R_DATA) & s_rready;

endmodule
